// File: rtl/ext_pkg.sv
// rtl/ext_pkg.sv - extension mode type and constants shared by the immediate pipe
package ext_pkg;

    localparam int EXT_MODE_W = 2;

    typedef enum logic [EXT_MODE_W-1:0] {
        SIGN   = 2'd0,
        ZERO   = 2'd1,
        LUI    = 2'd2,
        BRANCH = 2'd3
    } ext_mode_t;

endpackage

// File: rtl/ext_fifo.sv
// rtl/ext_fifo.sv - small power-of-two result buffer with level count and flush
module ext_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = (level == '0) ? '0 : mem[rptr];

endmodule

// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - immediate extension with a buffered, flow-controlled result queue
module imm_ext_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_imm,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [1:0]             out_mode,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            acc_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int SW = OUT_W + EXT_MODE_W;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    if (OUT_W < IN_W + 2) begin : g_bad_width
        $error("imm_ext_pipe: OUT_W must be at least IN_W+2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("imm_ext_pipe: DEPTH must be a power of two and at least 2");
    end

    ext_mode_t        mode;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;
    logic [SW-1:0]    rdata;
    logic             push;
    logic             pop;

    assign mode = ext_mode_t'(in_mode);
    assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

    always_comb begin
        ext = '0;
        case (mode)
            SIGN:    ext = sext;
            ZERO:    ext = {{(OUT_W-IN_W){1'b0}}, in_imm};
            LUI:     ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
            BRANCH:  ext = {sext[OUT_W-3:0], 2'b00};
            default: ext = '0;
        endcase
    end

    // in_ready looks only at the level, so a full buffer never passes through.
    assign in_ready  = (level != FULL);
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    ext_fifo #(
        .W     (SW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({in_mode, ext}),
        .rdata (rdata),
        .level (level)
    );

    assign out_mode = rdata[SW-1:OUT_W];
    assign out_data = rdata[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst)      acc_cnt <= '0;
        else if (push) acc_cnt <= acc_cnt + 16'd1;
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - randomized and directed checks of imm_ext_pipe against a queue model
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  out_mode;
    logic [1:0]  level;
    logic [15:0] acc_cnt;

    int n_vec = 0;
    int n_bad = 0;

    logic [33:0] mq [$];
    logic [15:0] m_acc = '0;

    imm_ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .level     (level),
        .acc_cnt   (acc_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_ext(logic [15:0] imm, logic [1:0] mode);
        longint s;
        longint b;
        s = longint'($signed(imm));
        b = s * 4;
        case (mode)
            2'd0:    return s[31:0];
            2'd1:    return 32'(imm);
            2'd2:    return 32'(imm) * 32'd65536;
            default: return b[31:0];
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("level",     32'(level),     32'(mq.size()));
        chk("in_ready",  32'(in_ready),  32'(mq.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("out_data",  out_data,       (mq.size() > 0) ? mq[0][31:0] : 32'd0);
        chk("out_mode",  32'(out_mode),  (mq.size() > 0) ? 32'(mq[0][33:32]) : 32'd0);
        chk("acc_cnt",   32'(acc_cnt),   32'(m_acc));
    endtask

    // Advance one clock: the model applies the same edge from the pre-edge inputs.
    task automatic step();
        bit do_push;
        bit do_pop;
        do_push = in_valid && (mq.size() < 2);
        do_pop  = out_ready && (mq.size() > 0);
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            m_acc = '0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({in_mode, ref_ext(in_imm, in_mode)});
                m_acc++;
            end
        end
        #1;
        compare_all();
    endtask

    task automatic offer(logic [1:0] mode, logic [15:0] imm);
        in_valid = 1'b1;
        in_mode  = mode;
        in_imm   = imm;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        logic [15:0] saved_acc;

        do_reset();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_data", out_data, 32'd0);

        out_ready = 1'b1;
        offer(2'd0, 16'h8001); step();
        chk("sign_8001", out_data, 32'hFFFF8001);
        offer(2'd0, 16'h7FFF); step();
        chk("sign_7fff", out_data, 32'h00007FFF);
        offer(2'd1, 16'h8001); step();
        chk("zero_8001", out_data, 32'h00008001);
        offer(2'd2, 16'h1234); step();
        chk("lui_1234", out_data, 32'h12340000);
        offer(2'd3, 16'hFFFF); step();
        chk("br_ffff", out_data, 32'hFFFFFFFC);
        offer(2'd3, 16'h0001); step();
        chk("br_0001", out_data, 32'h00000004);
        in_valid = 1'b0; step();

        do_reset();
        out_ready = 1'b0;
        offer(2'd1, 16'h000A); step();
        offer(2'd1, 16'h000B); step();
        chk("full_ready", 32'(in_ready), 32'd0);
        offer(2'd1, 16'h000C); step();
        chk("full_level", 32'(level), 32'd2);
        chk("full_head", out_data, 32'h0000000A);
        out_ready = 1'b1; step();
        chk("drain_b", out_data, 32'h0000000B);
        step();
        in_valid = 1'b0;
        chk("drain_c", out_data, 32'h0000000C);
        chk("acc_three", 32'(acc_cnt), 32'd3);
        step();
        chk("drain_empty", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        offer(2'd2, 16'h00AA); step();
        out_ready = 1'b1;
        offer(2'd2, 16'h00BB); step();
        chk("pp_level", 32'(level), 32'd1);
        chk("pp_head", out_data, 32'h00BB0000);
        in_valid = 1'b0; step();

        out_ready = 1'b0;
        offer(2'd0, 16'h1111); step();
        offer(2'd0, 16'h2222); step();
        saved_acc = m_acc;
        flush = 1'b1;
        offer(2'd0, 16'h3333); step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_data", out_data, 32'd0);
        chk("flush_acc", 32'(acc_cnt), 32'(saved_acc));

        offer(2'd1, 16'h0001); step();
        offer(2'd1, 16'h0002); step();
        in_valid = 1'b0;
        do_reset();
        chk("rst2_level", 32'(level), 32'd0);
        chk("rst2_acc", 32'(acc_cnt), 32'd0);
        chk("rst2_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            offer(2'($urandom_range(0, 3)), 16'($urandom));
            step();
        end
        in_valid = 1'b0;
        chk("acc_wrap", 32'(acc_cnt), 32'h0001);

        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
